// File: rtl/trdb_pkg.sv
// Shared types and defaults for the trace-encoder clock-gate controller.
package trdb_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_GATED = 2'd1,
    CG_WAKE  = 2'd2
  } clk_gate_state_e;

  localparam int CG_IDLE_CYCLES_DEF = 16;
  localparam int CG_WAKE_CYCLES_DEF = 2;

endpackage

// File: rtl/trdb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module trdb_sat_counter
  import trdb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: count_d takes its hold value first so no path through this block can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/trdb_clk_gate_ctrl.sv
// Clock-gate controller: stops the gated domain after an idle period and
// re-enables it on activity, holding ready_o low until the domain has settled.
module trdb_clk_gate_ctrl
  import trdb_pkg::*;
#(
  parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
  parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
  parameter int STAT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              pending_i,
  input  logic              force_on_i,
  output logic              gate_en_o,
  output logic              gated_o,
  input  logic              clear_stats_i,
  output logic [STAT_W-1:0] gated_cycles_o
);

  if (IDLE_CYCLES < 1) begin : g_chk_idle
    $error("trdb_clk_gate_ctrl: IDLE_CYCLES must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : g_chk_wake
    $error("trdb_clk_gate_ctrl: WAKE_CYCLES must be >= 1");
  end

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  clk_gate_state_e state_q, state_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]   wake_cnt_q, wake_cnt_d;
  logic            busy;

  assign busy = valid_i | pending_i | force_on_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      CG_RUN: begin
        // Busy on the threshold cycle wins and restarts the idle window.
        if (busy) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = CG_GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      CG_GATED: begin
        if (busy) begin
          state_d    = CG_WAKE;
          wake_cnt_d = '0;
        end
      end
      CG_WAKE: begin
        // Wake always runs to completion regardless of input activity.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = CG_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d    = CG_RUN;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CG_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  // Status is decoded from the state register only: no input reaches an output.
  assign gate_en_o = (state_q != CG_GATED);
  assign gated_o   = (state_q == CG_GATED);
  assign ready_o   = (state_q == CG_RUN);

  trdb_sat_counter #(
    .WIDTH (STAT_W)
  ) u_gated_stat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (state_q == CG_GATED),
    .clr_i   (clear_stats_i),
    .count_o (gated_cycles_o)
  );

endmodule
